// File: rtl/icache_tag_ram_ctrl_pkg.sv
// Shared types and constants for the L1.5 icache tag RAM controller.
package icache_tag_ctrl_pkg;

   localparam int unsigned TAG_DATA_WIDTH = 7;
   localparam int unsigned TAG_ADDR_WIDTH = 6;
   // The top bit of a tag entry is its valid flag; zero data means invalid.
   localparam int unsigned TAG_VALID_BIT  = TAG_DATA_WIDTH - 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      DONE  = 2'd2
   } tag_state_e;

endpackage

// File: rtl/icache_tag_ram_ctrl_if.sv
// Requester and tag-RAM port bundle of the icache tag RAM controller.
interface icache_tag_ram_ctrl_if
   import icache_tag_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = TAG_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = TAG_ADDR_WIDTH
);
   logic                  lookup_req_i;
   logic [ADDR_WIDTH-1:0] lookup_addr_i;
   logic                  lookup_gnt_o;
   logic                  lookup_rvalid_o;
   logic [DATA_WIDTH-1:0] lookup_rdata_o;
   logic                  refill_req_i;
   logic [ADDR_WIDTH-1:0] refill_addr_i;
   logic [DATA_WIDTH-1:0] refill_wdata_i;
   logic                  refill_gnt_o;
   logic                  flush_req_i;
   logic                  flush_ack_o;
   logic                  busy_o;
   logic                  ram_req_o;
   logic                  ram_we_o;
   logic [ADDR_WIDTH-1:0] ram_addr_o;
   logic [DATA_WIDTH-1:0] ram_wdata_o;
   logic [DATA_WIDTH-1:0] ram_rdata_i;

   // Controller view.
   modport slave (
      input  lookup_req_i, lookup_addr_i, refill_req_i, refill_addr_i,
             refill_wdata_i, flush_req_i, ram_rdata_i,
      output lookup_gnt_o, lookup_rvalid_o, lookup_rdata_o, refill_gnt_o,
             flush_ack_o, busy_o, ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o
   );

   // Cache controller plus tag RAM view.
   modport master (
      output lookup_req_i, lookup_addr_i, refill_req_i, refill_addr_i,
             refill_wdata_i, flush_req_i, ram_rdata_i,
      input  lookup_gnt_o, lookup_rvalid_o, lookup_rdata_o, refill_gnt_o,
             flush_ack_o, busy_o, ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o
   );

endinterface

// File: rtl/icache_tag_ram_ctrl.sv
// Arbitrates lookup/refill/flush access to one single-port icache tag RAM bank.
// Define TAG_FLUSH_ON_RESET_EN to start a full invalidate sweep out of reset.
module icache_tag_ram_ctrl
   import icache_tag_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = TAG_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = TAG_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   icache_tag_ram_ctrl_if.slave  bus
);

   localparam int unsigned CNT_LAST = (1 << ADDR_WIDTH) - 1;

   tag_state_e            r_state;
   tag_state_e            w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic [ADDR_WIDTH-1:0] w_cnt_nxt;
   logic                  r_rvalid;

   logic                  w_lookup_gnt;
   logic                  w_refill_gnt;
   logic                  w_ram_req;
   logic                  w_ram_we;
   logic [ADDR_WIDTH-1:0] w_ram_addr;
   logic [DATA_WIDTH-1:0] w_ram_wdata;
   logic                  w_busy;
   logic                  w_ack;

   // State, sweep counter and lookup read-valid registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
`ifdef TAG_FLUSH_ON_RESET_EN
         r_state  <= FLUSH;
`else
         r_state  <= IDLE;
`endif
         r_cnt    <= '0;
         r_rvalid <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_rvalid <= w_lookup_gnt;
      end
   end

   // Next state, fixed-priority arbitration and RAM port drive.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_lookup_gnt = 1'b0;
      w_refill_gnt = 1'b0;
      w_ram_req    = 1'b0;
      w_ram_we     = 1'b0;
      w_ram_addr   = '0;
      w_ram_wdata  = '0;
      w_busy       = 1'b0;
      w_ack        = 1'b0;

      case (r_state)
         FLUSH: begin
            w_busy      = 1'b1;
            w_ram_req   = 1'b1;
            w_ram_we    = 1'b1;
            w_ram_addr  = r_cnt;
            w_ram_wdata = DATA_WIDTH'(0);
            w_cnt_nxt   = r_cnt + ADDR_WIDTH'(1);
            if (r_cnt == ADDR_WIDTH'(CNT_LAST)) begin
               w_state_nxt = DONE;
            end
         end
         default: begin
            if (bus.refill_req_i) begin
               w_refill_gnt = 1'b1;
               w_ram_req    = 1'b1;
               w_ram_we     = 1'b1;
               w_ram_addr   = bus.refill_addr_i;
               w_ram_wdata  = bus.refill_wdata_i;
            end else if (bus.lookup_req_i) begin
               w_lookup_gnt = 1'b1;
               w_ram_req    = 1'b1;
               w_ram_addr   = bus.lookup_addr_i;
            end
            // A flush request in the ack cycle is dropped, not queued.
            if (r_state == DONE) begin
               w_ack       = 1'b1;
               w_state_nxt = IDLE;
            end else if (bus.flush_req_i) begin
               w_state_nxt = FLUSH;
               w_cnt_nxt   = '0;
            end
         end
      endcase
   end

   assign bus.lookup_gnt_o    = w_lookup_gnt;
   assign bus.refill_gnt_o    = w_refill_gnt;
   assign bus.lookup_rvalid_o = r_rvalid;
   assign bus.lookup_rdata_o  = bus.ram_rdata_i;
   assign bus.flush_ack_o     = w_ack;
   assign bus.busy_o          = w_busy;
   assign bus.ram_req_o       = w_ram_req;
   assign bus.ram_we_o        = w_ram_we;
   assign bus.ram_addr_o      = w_ram_addr;
   assign bus.ram_wdata_o     = w_ram_wdata;

endmodule

// File: doc/icache_tag_ram_ctrl.md
# icache_tag_ram_ctrl

Sequencer and arbiter for one L1.5 instruction-cache tag SRAM bank. It shares the single-port tag RAM between three requesters: the hit/miss lookup path (read), the refill path (tag write), and an internal flush engine that invalidates every entry. It sits between the L1.5 cache controller and the `ram_ws_rs_tag_scm`-style tag RAM instance, driving that RAM's req/write/addr/wdata and returning its rdata.

## Interface
- DATA_WIDTH, 7: tag entry width (valid bit + tag), must match the tag RAM.
- ADDR_WIDTH, 6: set-index width; the RAM holds 2**ADDR_WIDTH entries.
- clk  in  1  single clock; all state is on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- lookup_req_i  in  1  lookup read request.
- lookup_addr_i  in  ADDR_WIDTH  set index to read.
- lookup_gnt_o  out  1  lookup accepted this cycle.
- lookup_rvalid_o  out  1  lookup_rdata_o valid, one cycle after the grant.
- lookup_rdata_o  out  DATA_WIDTH  tag read data.
- refill_req_i  in  1  tag write request.
- refill_addr_i  in  ADDR_WIDTH  set index to write.
- refill_wdata_i  in  DATA_WIDTH  tag entry to write.
- refill_gnt_o  out  1  refill accepted this cycle.
- flush_req_i  in  1  single-cycle pulse starting a full invalidate.
- flush_ack_o  out  1  single-cycle pulse when the flush completes.
- busy_o  out  1  flush in progress.
- ram_req_o, ram_we_o  out  1  tag RAM request and write enable.
- ram_addr_o  out  ADDR_WIDTH  tag RAM address.
- ram_wdata_o  out  DATA_WIDTH  tag RAM write data.
- ram_rdata_i  in  DATA_WIDTH  tag RAM read data, one cycle after a read request.

## Operation
- FSM states: IDLE, FLUSH, DONE.
- IDLE: fixed priority refill > lookup. refill_gnt_o = refill_req_i; lookup_gnt_o = lookup_req_i & ~refill_req_i. Grants are combinational, same cycle as the request. The granted request drives the RAM port in that cycle.
- flush_req_i in IDLE: move to FLUSH next cycle. Clear the counter to 0. Requests in that same cycle are still arbitrated normally.
- FLUSH: one write per cycle. ram_we_o = 1, ram_wdata_o = 0, ram_addr_o = counter. The counter increments each cycle. Both grants are 0 and busy_o = 1.
- When the counter reaches 2**ADDR_WIDTH-1, that write is issued, then the FSM moves to DONE.
- DONE: lasts one cycle. flush_ack_o = 1, busy_o = 0. Arbitration behaves as in IDLE. The FSM then returns to IDLE.
- flush_req_i in FLUSH or DONE is ignored. No second sweep is queued.
- The counter is ADDR_WIDTH bits and wraps naturally. The last index is detected explicitly, not by overflow.
- lookup_rvalid_o is a register set from the lookup grant. lookup_rdata_o = ram_rdata_i, passed through directly.
- Refill and lookup to the same index in consecutive cycles are not forwarded: the RAM order decides the result. A lookup granted in cycle N followed by a refill in N+1 returns the old entry.
- Idle RAM port: ram_req_o = 0, ram_we_o = 0, address and data held at 0.

## Timing
- Reset values: FSM in IDLE, counter 0, lookup_rvalid_o 0, flush_ack_o 0, busy_o 0. All grants and RAM controls are 0 while no requests are present.
- Lookup latency: grant in cycle N, rvalid and rdata in cycle N+1.
- Refill: write performed in the grant cycle.
- Flush: exactly 2**ADDR_WIDTH write cycles. flush_ack_o pulses in the cycle after the last write. With the default ADDR_WIDTH this is 64 cycles plus the ack cycle.
- Reset asserted mid-flush: the flush is abandoned immediately with no ack, and the FSM restarts per Configuration.

## Configuration
- TAG_FLUSH_ON_RESET_EN defined: the reset state is FLUSH with counter 0 and busy_o = 1. Tags are invalidated automatically after every reset, and flush_ack_o pulses at the end.
- Undefined: the reset state is IDLE. Tag contents after reset are undefined until software or the controller issues flush_req_i.

## Structure
- Package icache_tag_ctrl_pkg holds the FSM state enum (IDLE/FLUSH/DONE) and the tag-entry valid-bit position constant.
- No sub-module. The tag RAM wrapper is instantiated by the parent, not inside this block.

## Test plan
- Reset, macro undefined -> all outputs 0, FSM IDLE. Macro defined -> busy_o = 1 for 64 cycles, RAM writes to 0..63 with data 0, one flush_ack_o pulse.
- lookup_req_i with addr 5 after a refill of addr 5 with 7'h55 -> gnt same cycle; next cycle rvalid = 1 and rdata = 7'h55.
- refill_req_i and lookup_req_i in the same cycle -> refill_gnt_o = 1 and lookup_gnt_o = 0. The next cycle, with refill_req_i low, grants the lookup.
- flush_req_i pulse, then lookup held high -> lookup_gnt_o = 0 for 64 cycles. RAM sees addresses 0..63 with we = 1. flush_ack_o pulses, and lookup is granted in the DONE cycle.
- flush_req_i pulsed again at cycle 10 of a flush -> ignored; exactly one ack.
- rst_n asserted at flush cycle 20 -> no ack; counter 0, and the state follows the Configuration rule.
